pb_debounce: RTL
================

# pb_debounce

Pushbutton conditioning stage in front of the CPU core's `pb[4:0]` input. Takes five raw, asynchronous, bouncing pushbutton lines and produces a clean debounced level plus a single-cycle press strobe per button. The CPU and LED logic consume `pb_press` as event inputs and `pb_level` as held state. One instance per board, clocked by the system clock.

## Interface

- `N_PB`, default 5: number of buttons.
- `DEBOUNCE_CYCLES`, default 100000: consecutive stable synchronized samples required to accept a level change. Legal range ≥ 2.
- `HOLD_CYCLES`, default 50000000: cycles a button must stay debounced-high before auto-repeat starts. Used only with `PB_REPEAT_EN`.
- `REPEAT_CYCLES`, default 10000000: auto-repeat period. Used only with `PB_REPEAT_EN`.

Ports:

- `clk` input 1: system clock. All logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `pb` input N_PB: raw pushbutton lines, asynchronous, active-high.
- `pb_level` output N_PB: debounced button state.
- `pb_press` output N_PB: one-cycle strobe on each accepted press, and on each auto-repeat when that feature is enabled.

## Operation

- Each bit is fully independent; no shared counters.
- **Synchronizer:** two-flop chain `s1 <= pb`, `s2 <= s1`. Only `s2` feeds the debounce logic.
- **Debounce counter:** `cnt`, width `$clog2(DEBOUNCE_CYCLES)`, one per bit.
  - If `s2 == pb_level`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `pb_level <= s2` and `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
  - Any single-cycle return of `s2` to the current level restarts the count from 0.
- **Press strobe:** `pb_press[i]` is high for exactly the cycle after `pb_level[i]` changes 0→1. A 1→0 change generates no strobe.
- **Per-bit state machine:**
  - IDLE: level 0.
  - HELD: level 1, no repeat yet.
  - REPEAT: only with the macro.
  - Transitions:
    - IDLE→HELD on accepted rise, with strobe.
    - HELD→IDLE on accepted fall.
    - HELD→REPEAT when the hold counter reaches HOLD_CYCLES-1.
    - REPEAT→IDLE on accepted fall.
- **Hold/repeat counter:** 32-bit, cleared on entry to HELD and to REPEAT. It never wraps in legal use; saturating is acceptable.
- **Reset:** all of the following are 0.
  - Outputs: `pb_level`, `pb_press`.
  - Internal: `s1`, `s2`, `cnt`, hold counter.
  - Every bit's state is IDLE.
  - A reset asserted while a press is being debounced discards the partial count. After reset is released, a button that is still held is re-debounced from scratch and produces one strobe.
- **Simultaneous events:**
  - Several bits accepted on the same edge strobe on the same cycle.
  - A release accepted on the same edge that a repeat pulse is due takes priority: no strobe, go to IDLE.

## Timing

- The raw `pb` is sampled high first at edge E and stays high. Then:
  - `s2` = 1 after edge E+1.
  - `pb_level` = 1 after edge E+DEBOUNCE_CYCLES+1.
  - `pb_press` = 1 for the single cycle after edge E+DEBOUNCE_CYCLES+2.
- Release latency is identical: DEBOUNCE_CYCLES+1 edges to `pb_level` = 0.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no change on either output.
- With repeat enabled:
  - First repeat strobe: HOLD_CYCLES cycles after the press strobe.
  - Subsequent strobes: every REPEAT_CYCLES cycles while held.
- `pb_press` is never high on two consecutive cycles for the same bit.

## Configuration

- `PB_REPEAT_EN` defined: the HELD→REPEAT path and the hold/repeat counter are compiled in, and auto-repeat strobes are generated as described above.
- Not defined: the REPEAT state and hold counter are absent. A held button produces exactly one strobe per accepted press; `HOLD_CYCLES` and `REPEAT_CYCLES` are ignored.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, and a 10 ps clock.

1. **Reset:** hold `rst`=1 for 15 cycles with `pb`=5'b11111. Outputs must stay 0 throughout. After release, `pb_level` = 5'b11111 at edge 6 and `pb_press` = 5'b11111 for one cycle at edge 7.
2. **Clean press on `pb[0]`:** rise at edge E. `pb_level[0]` rises after E+5; `pb_press[0]` is high for exactly one cycle after E+6. Release then gives `pb_level[0]`=0 five edges later with no strobe.
3. **Bounce on `pb[2]`:** toggle 1,0,1,0 on successive cycles, then hold high. No output activity during the toggling. Exactly one strobe, occurring DEBOUNCE_CYCLES+2 edges after the final rise.
4. **Simultaneous press:** `pb` = 5'b10010 on the same edge. `pb_press` = 5'b10010 on a single cycle.
5. **Repeat, `PB_REPEAT_EN` defined:** hold `pb[4]` for 60 cycles. Strobes occur at press, press+20, press+28, press+36, and so on. Release: the strobes stop and the state returns to IDLE.
6. **Repeat, `PB_REPEAT_EN` not defined:** same stimulus as scenario 5. Exactly one strobe.

Source files
------------

// File: rtl/pb_debounce.sv
// Five-line pushbutton conditioner: 2-flop synchronizer, per-bit debounce and one-cycle press strobe.
// Auto-repeat while held is compiled in only when PB_REPEAT_EN is defined.
module pb_debounce #(
  parameter int N_PB            = 5,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_PB-1:0] pb,
  output logic [N_PB-1:0] pb_level,
  output logic [N_PB-1:0] pb_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 2) begin : g_bad_params
    $error("pb_debounce: illegal parameter values");
  end

`ifdef PB_REPEAT_EN
  localparam logic [31:0] HOLD_MAX = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] REP_MAX  = 32'(REPEAT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;
`else
  typedef enum logic {IDLE, HELD} state_t;
`endif

  for (genvar i = 0; i < N_PB; i++) begin : g_bit
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_q, s1_d, s2_q, s2_d;
    logic             level_q, level_d, press_q, press_d;
`ifdef PB_REPEAT_EN
    logic [31:0]      hold_q, hold_d;
`endif

    always_comb begin
      s1_d    = pb[i];
      s2_d    = s1_q;
      level_d = level_q;
      cnt_d   = cnt_q;
      state_d = state_q;
      press_d = 1'b0;
`ifdef PB_REPEAT_EN
      hold_d  = hold_q;
`endif
      // Any sample that agrees with the accepted level restarts the stability count.
      if (s2_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        level_d = s2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (level_q) begin
            state_d = HELD;
            press_d = 1'b1;
`ifdef PB_REPEAT_EN
            hold_d  = '0;
`endif
          end
        end
        HELD: begin
          if (!level_q) begin
            state_d = IDLE;
`ifdef PB_REPEAT_EN
          end else if (hold_q == HOLD_MAX) begin
            state_d = REPEAT;
            press_d = 1'b1;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 32'd1;
`endif
          end
        end
`ifdef PB_REPEAT_EN
        // A release seen on the edge a repeat is due wins: no strobe.
        REPEAT: begin
          if (!level_q) begin
            state_d = IDLE;
          end else if (hold_q == REP_MAX) begin
            press_d = 1'b1;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 32'd1;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q    <= 1'b0;
        s2_q    <= 1'b0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        cnt_q   <= '0;
        state_q <= IDLE;
`ifdef PB_REPEAT_EN
        hold_q  <= '0;
`endif
      end else begin
        s1_q    <= s1_d;
        s2_q    <= s2_d;
        level_q <= level_d;
        press_q <= press_d;
        cnt_q   <= cnt_d;
        state_q <= state_d;
`ifdef PB_REPEAT_EN
        hold_q  <= hold_d;
`endif
      end
    end

    assign pb_level[i] = level_q;
    assign pb_press[i] = press_q;
  end

endmodule
